// File: rtl/fetch_pkg.sv
// Shared types and widths for the instruction fetch unit.
// Optional perf counters are enabled with FETCH_PERF_EN.
package fetch_pkg;
    localparam int ADDR_W    = 12;
    localparam int INSTR_W   = 19;
    localparam int BUF_DEPTH = 2;

    typedef enum logic [1:0] {
        FS_IDLE,
        FS_RUN,
        FS_HALT
    } fetch_state_t;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
    } fetch_entry_t;
endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Memory-read and decode-side handshake bundle of the fetch unit.
interface instruction_fetch_unit_if;
    import fetch_pkg::*;

    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_instr;
    logic               out_valid;
    logic               out_ready;
    logic [INSTR_W-1:0] out_instr;
    logic [ADDR_W-1:0]  out_pc;

    modport master (
        output imem_addr,
        input  imem_instr,
        output out_valid,
        input  out_ready,
        output out_instr,
        output out_pc
    );

    modport slave (
        input  imem_addr,
        output imem_instr,
        input  out_valid,
        output out_ready,
        input  out_instr,
        input  out_pc
    );
endinterface

// File: rtl/fetch_queue.sv
// Two-entry fetch FIFO with flush and same-cycle push+pop.
module fetch_queue
    import fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t din,
    output fetch_entry_t head,
    output logic         full,
    output logic         empty,
    output logic         flush_drop
);
    fetch_entry_t slot0;
    fetch_entry_t slot1;
    logic [1:0]   count;
    logic         do_pop;
    logic         do_push;

    assign empty   = (count == 2'd0);
    assign full    = (count == 2'(BUF_DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? '0 : slot0;

    // A word popped in the flush cycle is consumed, not discarded
    assign flush_drop = flush && (count != {1'b0, do_pop});

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= 2'd0;
            slot0 <= '0;
            slot1 <= '0;
        end else if (flush) begin
            count <= 2'd0;
        end else begin
            case ({do_push, do_pop})
                2'b11: begin
                    if (full) begin
                        slot0 <= slot1;
                        slot1 <= din;
                    end else begin
                        slot0 <= din;
                    end
                end
                2'b01: begin
                    slot0 <= slot1;
                    count <= count - 2'd1;
                end
                2'b10: begin
                    if (empty) slot0 <= din;
                    else       slot1 <= din;
                    count <= count + 2'd1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/instruction_fetch_unit.sv
// PC/FSM owner feeding a 2-entry fetch queue toward decode.
// Define FETCH_PERF_EN to add saturating fetch/flush counters.
module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        halt_req,
    input  logic                        redirect_valid,
    input  logic [ADDR_W-1:0]           redirect_target,
    instruction_fetch_unit_if.master    bus,
`ifdef FETCH_PERF_EN
    output logic [15:0]                 perf_fetch_cnt,
    output logic [15:0]                 perf_flush_cnt,
`endif
    output logic                        busy
);
    fetch_state_t      state;
    fetch_state_t      state_nx;
    logic [ADDR_W-1:0] pc;
    logic              pop;
    logic              fetch;
    logic              q_full;
    logic              q_empty;
    logic              flush_drop;
    fetch_entry_t      head;
    fetch_entry_t      din;

    assign bus.out_valid = !q_empty;
    assign bus.out_instr = head.instr;
    assign bus.out_pc    = head.pc;
    assign bus.imem_addr = pc;
    assign busy          = (state == FS_RUN);

    assign pop   = bus.out_valid && bus.out_ready;
    // Full queue still fetches when the head leaves this cycle
    assign fetch = (state == FS_RUN) && !redirect_valid
                && (!q_full || pop);
    assign din   = '{instr: bus.imem_instr, pc: pc};

    fetch_queue u_queue (
        .clk        (clk),
        .rst        (rst),
        .push       (fetch),
        .pop        (pop),
        .flush      (redirect_valid),
        .din        (din),
        .head       (head),
        .full       (q_full),
        .empty      (q_empty),
        .flush_drop (flush_drop)
    );

    always_comb begin
        state_nx = state;
        unique case (state)
            FS_IDLE: if (start)    state_nx = FS_RUN;
            FS_RUN:  if (halt_req) state_nx = FS_HALT;
            FS_HALT: if (start)    state_nx = FS_RUN;
            default:               state_nx = FS_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FS_IDLE;
            pc    <= RESET_PC;
        end else begin
            state <= state_nx;
            if (redirect_valid) pc <= redirect_target;
            else if (fetch)     pc <= pc + 1'b1;
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (fetch && perf_fetch_cnt != 16'hFFFF)
                perf_fetch_cnt <= perf_fetch_cnt + 16'd1;
            if (flush_drop && perf_flush_cnt != 16'hFFFF)
                perf_flush_cnt <= perf_flush_cnt + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench: queue-level reference model vs fetch unit.
module tb_instruction_fetch_unit;
    localparam int RST_PC = 0;
    localparam int S_IDLE = 0;
    localparam int S_RUN  = 1;
    localparam int S_HALT = 2;

    logic        clk = 0;
    logic        rst;
    logic        start;
    logic        halt_req;
    logic        redirect_valid;
    logic [11:0] redirect_target;
    logic        busy;
`ifdef FETCH_PERF_EN
    logic [15:0] perf_fetch_cnt;
    logic [15:0] perf_flush_cnt;
`endif

    logic [18:0] mem [4096];

    instruction_fetch_unit_if bus();

    assign bus.imem_instr = mem[bus.imem_addr];

    instruction_fetch_unit #(.RESET_PC(12'd0)) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .halt_req        (halt_req),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .bus             (bus),
`ifdef FETCH_PERF_EN
        .perf_fetch_cnt  (perf_fetch_cnt),
        .perf_flush_cnt  (perf_flush_cnt),
`endif
        .busy            (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int pops   = 0;
    bit armed  = 0;

    int m_state;
    int m_pc;
    int m_fc;
    int m_flc;
    logic [30:0] expq[$];

    task automatic chk(string name, int act, int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0h want %0h at %0t",
                     name, act, req, $time);
        end
    endtask

    // Reference model: whole-queue view, updated on each edge
    always @(posedge clk) begin
        if (rst) begin
            m_state = S_IDLE;
            m_pc    = RST_PC;
            m_fc    = 0;
            m_flc   = 0;
            expq.delete();
            armed   = 1;
        end else begin
            if (redirect_valid) begin
                if (expq.size() > 0 && m_flc < 65535) m_flc++;
                expq.delete();
                m_pc = int'(redirect_target);
            end else if (m_state == S_RUN && expq.size() < 2) begin
                expq.push_back({mem[m_pc], 12'(m_pc)});
                m_pc = (m_pc + 1) % 4096;
                if (m_fc < 65535) m_fc++;
            end
            case (m_state)
                S_IDLE:  if (start)    m_state = S_RUN;
                S_RUN:   if (halt_req) m_state = S_HALT;
                default: if (start)    m_state = S_RUN;
            endcase
        end
    end

    // Monitor: compare outputs mid-cycle, retire accepted words
    always @(negedge clk) begin
        if (armed) begin
            chk("out_valid", int'(bus.out_valid), int'(expq.size() != 0));
            if (expq.size() != 0) begin
                chk("out_pc", int'(bus.out_pc), int'(expq[0][11:0]));
                chk("out_instr", int'(bus.out_instr), int'(expq[0][30:12]));
            end else begin
                chk("out_pc_zero", int'(bus.out_pc), 0);
                chk("out_instr_zero", int'(bus.out_instr), 0);
            end
            chk("imem_addr", int'(bus.imem_addr), m_pc);
            chk("busy", int'(busy), int'(m_state == S_RUN));
`ifdef FETCH_PERF_EN
            chk("perf_fetch", int'(perf_fetch_cnt), m_fc);
            chk("perf_flush", int'(perf_flush_cnt), m_flc);
`endif
            if (expq.size() != 0 && bus.out_ready) begin
                void'(expq.pop_front());
                pops++;
            end
        end
    end

    task automatic cyc(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1;
        cyc(1);
        start = 0;
    endtask

    task automatic pulse_halt();
        halt_req = 1;
        cyc(1);
        halt_req = 0;
    endtask

    task automatic redirect(logic [11:0] t);
        redirect_valid  = 1;
        redirect_target = t;
        cyc(1);
        redirect_valid  = 0;
    endtask

    initial begin
        rst = 1;
        start = 0;
        halt_req = 0;
        redirect_valid = 0;
        redirect_target = 0;
        bus.out_ready = 0;
        for (int i = 0; i < 4096; i++) mem[i] = 19'($urandom);
        mem[2] = 19'h2000F;
        cyc(3);
        rst = 0;
        cyc(2);

        // streaming from reset
        bus.out_ready = 1;
        pulse_start();
        cyc(8);

        // decode stall
        bus.out_ready = 0;
        cyc(5);
        bus.out_ready = 1;
        cyc(4);

        // redirect on full queue
        bus.out_ready = 0;
        cyc(3);
        redirect(12'h100);
        bus.out_ready = 1;
        cyc(6);

        // entry point at top of address space, wrap
        pulse_halt();
        cyc(3);
        redirect(12'hFFF);
        pulse_start();
        cyc(6);

        // halt mid-stream and resume
        pulse_halt();
        cyc(6);
        pulse_start();
        cyc(5);

        // reset with full queue
        bus.out_ready = 0;
        cyc(3);
        rst = 1;
        cyc(1);
        rst = 0;
        cyc(2);
        bus.out_ready = 1;
        pulse_start();
        cyc(4);

        // halt_req wins over start in RUN
        start = 1;
        halt_req = 1;
        cyc(1);
        start = 0;
        halt_req = 0;
        cyc(3);

        for (int i = 0; i < 4000; i++) begin
            bus.out_ready   = ($urandom_range(0, 3) != 0);
            start           = ($urandom_range(0, 15) == 0);
            halt_req        = ($urandom_range(0, 29) == 0);
            redirect_valid  = ($urandom_range(0, 24) == 0);
            redirect_target = ($urandom_range(0, 3) == 0)
                            ? 12'hFFE + 12'($urandom_range(0, 1))
                            : 12'($urandom);
            rst             = ($urandom_range(0, 499) == 0);
            cyc(1);
        end
        rst = 0;
        start = 0;
        halt_req = 0;
        redirect_valid = 0;
        cyc(4);

        chk("handshakes_seen", int'(pops > 500), 1);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
